rv32i_decode_pipe: RTL and testbench
====================================

# rv32i_decode_pipe

Parametrised RV32I decode stage with an integrated ID/EX pipeline register, register file, load-use hazard interlock, flush and valid/ready handshakes on both sides. It sits between the IF/ID register and the execute stage. It generalises the plain combinational decode stage with a configurable data width and register count, same-cycle write-back bypass, bubble insertion and a saturating stall counter.

## Interface
- XLEN, 32: data and PC width in bits.
- NREG, 32: architectural register count, 16 or 32; index width RW = $clog2(NREG).
- CNT_W, 16: width of the stall counter.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  decode accepts the instruction this cycle.
- PC_IN  in  XLEN  PC of the incoming instruction.
- INST_IN  in  32  incoming instruction.
- wb_we  in  1  write-back enable.
- wb_rd  in  RW  write-back destination.
- wb_data  in  XLEN  write-back data.
- flush  in  1  squash the incoming and registered instruction (taken branch or jump).
- ex_ready  in  1  execute stage consumes the ID/EX contents this cycle.
- out_valid  out  1  ID/EX register holds a valid instruction.
- CTRL_WB_OUT  out  2  {RegWrite, MemtoReg}.
- CTRL_MEM_OUT  out  3  {Branch, MemRead, MemWrite}.
- CTRL_EX_OUT  out  4  {ALUOp[2:0], ALUSrc}.
- PC_OUT, REG1_OUT, REG2_OUT, IMM_OUT  out  XLEN  registered PC, rs1 and rs2 operands, and sign-extended immediate.
- INST_OUT  out  32  registered instruction.
- stall_cnt  out  CNT_W  count of load-use bubbles inserted.

## Operation
- Decode follows the team's Control and ImmGen encodings:
  - Branch = opcode 1100011.
  - MemRead = MemtoReg = opcode 0000011.
  - MemWrite = opcode 0100011.
  - RegWrite is set for R, I-ALU, load, JAL, JALR, LUI and AUIPC.
  - ALUSrc = 1 for every opcode except R-type and branch.
- The immediate is sign-extended to XLEN.
- Register file: NREG x XLEN entries.
  - Register 0 reads as 0; writes to it are ignored.
  - Writes occur at the rising edge when wb_we=1 and wb_rd != 0.
  - Indices at or above NREG are ignored on write and read as 0.
- Bypass: when wb_we=1, wb_rd != 0 and wb_rd equals rs1 or rs2, the matching operand takes wb_data in the same cycle.
- Hazard: hazard = out_valid & CTRL_MEM_OUT[1] & (INST_OUT[11:7] != 0) & (INST_OUT[11:7] == rs1, or INST_OUT[11:7] == rs2 where the opcode is R, S or B).
- Pipeline register update rules:
  - advance = !out_valid | ex_ready.
  - in_ready = advance & !hazard & !flush.
  - flush=1: out_valid <- 0, all CTRL outputs <- 0, input not captured. Flush has priority over every other rule.
  - in_valid & in_ready: capture all outputs; out_valid <- 1.
  - hazard & ex_ready: bubble. out_valid <- 0, CTRL outputs <- 0, stall_cnt increments and saturates at all-ones.
  - advance without a capture: out_valid <- 0, CTRL outputs <- 0.
  - Otherwise the register holds.
- Whenever out_valid=0, all CTRL outputs are 0, so a bubble is a NOP.

## Timing
- Reset, applied asynchronously:
  - All outputs are 0: out_valid, CTRL_*, PC_OUT, REG*_OUT, IMM_OUT, INST_OUT and stall_cnt.
  - All registers are cleared to 0.
  - in_ready is 1 after reset is released.
- Latency is one cycle from an accepted INST_IN to valid outputs.
- Throughput is one instruction per cycle when ex_ready is held at 1.
- A load-use pair costs exactly one bubble cycle. The dependent instruction is accepted on the cycle after the bubble.
- Simultaneous write-back and read of the same register delivers the new value through the bypass.
- Simultaneous flush and hazard: the flush wins and stall_cnt does not increment.
- in_ready is combinational from ex_ready, flush and INST_IN.
- Reset asserted mid-stall clears the pending stall state immediately.

## Test plan
- Reset: assert rst mid-stream -> every output is 0 immediately, in_ready=1 after release, and reading x5 returns 0.
- Write-back bypass and x0:
  - wb_we=1, wb_rd=5, wb_data=0xDEADBEEF together with add x1,x5,x0 -> next cycle REG1_OUT=0xDEADBEEF, REG2_OUT=0, CTRL_WB_OUT=2'b10.
  - wb_rd=0 with any data -> x0 still reads as 0.
- Load-use interlock: lw x3,4(x2) followed by add x4,x3,x1, ex_ready=1 ->
  - cycle 1: lw outputs with CTRL_MEM_OUT=3'b010, CTRL_WB_OUT=2'b11 and IMM_OUT=4.
  - cycle 2: bubble, out_valid=0 and CTRL outputs 0; stall_cnt=1.
  - cycle 3: the add is registered.
- Backpressure: ex_ready=0 for 3 cycles with a valid instruction held -> all outputs remain stable and in_ready=0; the next instruction is accepted on the cycle ex_ready returns to 1.
- Flush priority: flush=1 asserted together with a hazard and in_valid=1 -> out_valid=0, stall_cnt unchanged, and the input is not captured.
- Parametrisation:
  - NREG=16: a write to x20 is ignored and reading x20 returns 0.
  - CNT_W=2: five forced bubbles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/rv32i_decode_pipe.sv
// rv32i_decode_pipe: RV32I decode, register file, load-use interlock and
// ID/EX pipeline register with valid/ready handshakes on both sides.
module rv32i_decode_pipe #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  PC_IN,
    input  logic [31:0]      INST_IN,
    input  logic             wb_we,
    input  logic [RW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             out_valid,
    output logic [1:0]       CTRL_WB_OUT,
    output logic [2:0]       CTRL_MEM_OUT,
    output logic [3:0]       CTRL_EX_OUT,
    output logic [XLEN-1:0]  PC_OUT,
    output logic [XLEN-1:0]  REG1_OUT,
    output logic [XLEN-1:0]  REG2_OUT,
    output logic [XLEN-1:0]  IMM_OUT,
    output logic [31:0]      INST_OUT,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [1:0]      wb;
        logic [2:0]      mem;
        logic [3:0]      ex;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [XLEN-1:0] imm;
        logic [31:0]     inst;
    } id_ex_t;

    id_ex_t          d;
    id_ex_t          q;
    logic [XLEN-1:0] rf [NREG];
    logic [6:0]      op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      ex_rd;
    logic            is_r, is_i, is_ld, is_st, is_br;
    logic            is_jal, is_jalr, is_lui, is_auipc;
    logic            uses_rs2;
    logic [2:0]      aluop;
    logic [31:0]     imm32;
    logic            hazard;
    logic            advance;

    assign op       = INST_IN[6:0];
    assign rs1      = INST_IN[19:15];
    assign rs2      = INST_IN[24:20];
    assign is_r     = op == OP_R;
    assign is_i     = op == OP_I;
    assign is_ld    = op == OP_LD;
    assign is_st    = op == OP_ST;
    assign is_br    = op == OP_BR;
    assign is_jal   = op == OP_JAL;
    assign is_jalr  = op == OP_JALR;
    assign is_lui   = op == OP_LUI;
    assign is_auipc = op == OP_AUIPC;
    assign uses_rs2 = is_r | is_st | is_br;

    // Out-of-range indices and x0 read as zero; write-back bypasses the file.
    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] idx);
        logic in_range;
        in_range = (32'(idx) >> RW) == 32'd0;
        if (idx == 5'd0 || !in_range) return '0;
        if (wb_we && 5'(wb_rd) == idx) return wb_data;
        return rf[idx[RW-1:0]];
    endfunction

    always_comb begin
        aluop = 3'b000;
        unique case (1'b1)
            is_r:             aluop = 3'b010;
            is_i:             aluop = 3'b011;
            is_br:            aluop = 3'b001;
            is_jal | is_jalr: aluop = 3'b100;
            is_lui:           aluop = 3'b101;
            is_auipc:         aluop = 3'b110;
            default:          aluop = 3'b000;
        endcase
    end

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_ld | is_i | is_jalr:
                imm32 = {{20{INST_IN[31]}}, INST_IN[31:20]};
            is_st:
                imm32 = {{20{INST_IN[31]}}, INST_IN[31:25], INST_IN[11:7]};
            is_br:
                imm32 = {{19{INST_IN[31]}}, INST_IN[31], INST_IN[7],
                         INST_IN[30:25], INST_IN[11:8], 1'b0};
            is_lui | is_auipc:
                imm32 = {INST_IN[31:12], 12'd0};
            is_jal:
                imm32 = {{11{INST_IN[31]}}, INST_IN[31], INST_IN[19:12],
                         INST_IN[20], INST_IN[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    always_comb begin
        d.wb   = {is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc,
                  is_ld};
        d.mem  = {is_br, is_ld, is_st};
        d.ex   = {aluop, ~(is_r | is_br)};
        d.pc   = PC_IN;
        d.r1   = rd_port(rs1);
        d.r2   = rd_port(rs2);
        d.imm  = XLEN'($signed(imm32));
        d.inst = INST_IN;
    end

    assign ex_rd    = q.inst[11:7];
    assign hazard   = out_valid & q.mem[1] & (ex_rd != 5'd0) &
                      ((ex_rd == rs1) | (uses_rs2 & (ex_rd == rs2)));
    assign advance  = ~out_valid | ex_ready;
    assign in_ready = advance & ~hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) rf[k] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Bubbles, flushes and drains only clear valid and control; data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            out_valid <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            q.wb      <= '0;
            q.mem     <= '0;
            q.ex      <= '0;
        end else if (in_valid && in_ready) begin
            q         <= d;
            out_valid <= 1'b1;
        end else if (hazard && ex_ready) begin
            out_valid <= 1'b0;
            q.wb      <= '0;
            q.mem     <= '0;
            q.ex      <= '0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (advance) begin
            out_valid <= 1'b0;
            q.wb      <= '0;
            q.mem     <= '0;
            q.ex      <= '0;
        end
    end

    assign CTRL_WB_OUT  = q.wb;
    assign CTRL_MEM_OUT = q.mem;
    assign CTRL_EX_OUT  = q.ex;
    assign PC_OUT       = q.pc;
    assign REG1_OUT     = q.r1;
    assign REG2_OUT     = q.r2;
    assign IMM_OUT      = q.imm;
    assign INST_OUT     = q.inst;

endmodule

// File: tb/tb_rv32i_decode_pipe.sv
// tb_rv32i_decode_pipe: directed and randomized checks of the decode stage
// against an instruction-level reference model.
module tb_rv32i_decode_pipe;

    localparam int C_R     = 0;
    localparam int C_I     = 1;
    localparam int C_LD    = 2;
    localparam int C_ST    = 3;
    localparam int C_BR    = 4;
    localparam int C_JAL   = 5;
    localparam int C_JALR  = 6;
    localparam int C_LUI   = 7;
    localparam int C_AUIPC = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, wb_we, flush, ex_ready, out_valid;
    logic [31:0] pc_in, inst_in, wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  ctrl_wb;
    logic [2:0]  ctrl_mem;
    logic [3:0]  ctrl_ex;
    logic [31:0] pc_out, reg1, reg2, imm, inst_out;
    logic [15:0] stall_cnt;

    logic        s_rst, s_in_valid, s_in_ready, s_wb_we, s_flush;
    logic        s_ex_ready, s_out_valid;
    logic [31:0] s_pc_in, s_inst_in, s_wb_data;
    logic [3:0]  s_wb_rd;
    logic [1:0]  s_ctrl_wb;
    logic [2:0]  s_ctrl_mem;
    logic [3:0]  s_ctrl_ex;
    logic [31:0] s_pc_out, s_reg1, s_reg2, s_imm, s_inst_out;
    logic [1:0]  s_stall_cnt;

    rv32i_decode_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .PC_IN(pc_in), .INST_IN(inst_in), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
        .out_valid(out_valid), .CTRL_WB_OUT(ctrl_wb),
        .CTRL_MEM_OUT(ctrl_mem), .CTRL_EX_OUT(ctrl_ex), .PC_OUT(pc_out),
        .REG1_OUT(reg1), .REG2_OUT(reg2), .IMM_OUT(imm),
        .INST_OUT(inst_out), .stall_cnt(stall_cnt)
    );

    rv32i_decode_pipe #(.XLEN(32), .NREG(16), .CNT_W(2)) u_small (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .PC_IN(s_pc_in), .INST_IN(s_inst_in),
        .wb_we(s_wb_we), .wb_rd(s_wb_rd), .wb_data(s_wb_data),
        .flush(s_flush), .ex_ready(s_ex_ready), .out_valid(s_out_valid),
        .CTRL_WB_OUT(s_ctrl_wb), .CTRL_MEM_OUT(s_ctrl_mem),
        .CTRL_EX_OUT(s_ctrl_ex), .PC_OUT(s_pc_out), .REG1_OUT(s_reg1),
        .REG2_OUT(s_reg2), .IMM_OUT(s_imm), .INST_OUT(s_inst_out),
        .stall_cnt(s_stall_cnt)
    );

    int          checks = 0;
    int          errors = 0;

    logic        m_valid;
    logic [1:0]  m_wb;
    logic [2:0]  m_mem;
    logic [3:0]  m_ex;
    logic [31:0] m_pc, m_r1, m_r2, m_imm, m_inst;
    logic [15:0] m_cnt;
    logic [31:0] m_rf [32];
    int          cur_cls;
    logic [31:0] cur_imm;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int cls,
                                        input logic [4:0] rd, rs1, rs2,
                                        input logic [31:0] im);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = 3'($urandom);
        f7 = 7'($urandom);
        case (cls)
            C_R:    return {f7, rs2, rs1, f3, rd, 7'b0110011};
            C_I:    return {im[11:0], rs1, f3, rd, 7'b0010011};
            C_LD:   return {im[11:0], rs1, f3, rd, 7'b0000011};
            C_JALR: return {im[11:0], rs1, 3'b000, rd, 7'b1100111};
            C_ST:   return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
            C_BR:   return {im[12], im[10:5], rs2, rs1, f3, im[4:1],
                            im[11], 7'b1100011};
            C_JAL:  return {im[20], im[10:1], im[11], im[19:12], rd,
                            7'b1101111};
            C_LUI:  return {im[31:12], rd, 7'b0110111};
            default: return {im[31:12], rd, 7'b0010111};
        endcase
    endfunction

    function automatic logic [31:0] rimm(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            C_R:            return 32'd0;
            C_BR:           return {{19{r[12]}}, r[12:1], 1'b0};
            C_JAL:          return {{11{r[20]}}, r[20:1], 1'b0};
            C_LUI, C_AUIPC: return {r[31:12], 12'd0};
            default:        return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    // {RegWrite, MemtoReg}, {Branch, MemRead, MemWrite}, {ALUOp, ALUSrc}
    function automatic logic [8:0] exp_ctrl(input int cls);
        case (cls)
            C_R:           return {2'b10, 3'b000, 4'b0100};
            C_I:           return {2'b10, 3'b000, 4'b0111};
            C_LD:          return {2'b11, 3'b010, 4'b0001};
            C_ST:          return {2'b00, 3'b001, 4'b0001};
            C_BR:          return {2'b00, 3'b100, 4'b0010};
            C_JAL, C_JALR: return {2'b10, 3'b000, 4'b1001};
            C_LUI:         return {2'b10, 3'b000, 4'b1011};
            default:       return {2'b10, 3'b000, 4'b1101};
        endcase
    endfunction

    function automatic logic [31:0] rdreg(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_we && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wb = 0; m_mem = 0; m_ex = 0;
        m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_inst = 0; m_cnt = 0;
        for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("ctrl_wb", 32'(ctrl_wb), 32'(m_wb));
        chk("ctrl_mem", 32'(ctrl_mem), 32'(m_mem));
        chk("ctrl_ex", 32'(ctrl_ex), 32'(m_ex));
        chk("pc_out", pc_out, m_pc);
        chk("reg1", reg1, m_r1);
        chk("reg2", reg2, m_r2);
        chk("imm", imm, m_imm);
        chk("inst_out", inst_out, m_inst);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    task automatic set_inst(input int cls, input logic [4:0] rd, rs1, rs2,
                            input logic [31:0] im);
        cur_cls = cls;
        cur_imm = im;
        inst_in = enc(cls, rd, rs1, rs2, im);
        pc_in   = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic tick();
        logic [4:0]  lrd, a, b;
        logic        hz, adv, rdy, two;
        logic [31:0] c1, c2;
        logic [8:0]  ct;
        #1;
        a   = inst_in[19:15];
        b   = inst_in[24:20];
        two = (cur_cls == C_R) || (cur_cls == C_ST) || (cur_cls == C_BR);
        lrd = m_inst[11:7];
        hz  = m_valid && m_mem[1] && lrd != 0 &&
              (lrd == a || (two && lrd == b));
        adv = !m_valid || ex_ready;
        rdy = adv && !hz && !flush;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        c1  = rdreg(a);
        c2  = rdreg(b);
        ct  = exp_ctrl(cur_cls);
        @(posedge clk);
        #1;
        if (flush || (!(in_valid && rdy) && adv)) begin
            m_valid = 0; m_wb = 0; m_mem = 0; m_ex = 0;
            if (!flush && hz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            {m_wb, m_mem, m_ex} = ct;
            m_pc = pc_in; m_r1 = c1; m_r2 = c2;
            m_imm = cur_imm; m_inst = inst_in;
        end
        if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        in_valid = 0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] wa, wb2, wl;
        rst = 0; in_valid = 0; wb_we = 0; flush = 0; ex_ready = 1;
        wb_rd = 0; wb_data = 0; pc_in = 0; inst_in = 0;
        cur_cls = C_R; cur_imm = 0;
        s_rst = 1; s_in_valid = 0; s_wb_we = 0; s_flush = 0;
        s_ex_ready = 1; s_wb_rd = 0; s_wb_data = 0; s_pc_in = 0;
        s_inst_in = 0;
        #3;
        do_reset();

        // same-cycle write-back bypass into rs1
        wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        set_inst(C_R, 1, 5, 0, 0);
        in_valid = 1; ex_ready = 1;
        tick();
        chk("bypass_r1", reg1, 32'hDEADBEEF);
        chk("bypass_r2", reg2, 32'd0);
        chk("bypass_wb", 32'(ctrl_wb), 32'd2);

        wb_rd = 0; wb_data = 32'h12345678;
        set_inst(C_R, 2, 0, 0, 0);
        tick();
        chk("x0_r1", reg1, 32'd0);
        wb_we = 0;
        set_inst(C_R, 6, 0, 5, 0);
        tick();
        chk("x0_kept", reg1, 32'd0);
        chk("x5_file", reg2, 32'hDEADBEEF);

        // load-use interlock
        set_inst(C_LD, 3, 2, 0, 32'd4);
        tick();
        chk("lw_mem", 32'(ctrl_mem), 32'd2);
        chk("lw_wb", 32'(ctrl_wb), 32'd3);
        chk("lw_imm", imm, 32'd4);
        set_inst(C_R, 4, 3, 1, 0);
        wa = inst_in;
        tick();
        chk("bub_valid", 32'(out_valid), 32'd0);
        chk("bub_mem", 32'(ctrl_mem), 32'd0);
        chk("bub_cnt", 32'(stall_cnt), 32'd1);
        tick();
        chk("lu_add", inst_out, wa);

        // backpressure
        set_inst(C_I, 11, 1, 0, 32'hFFFF_FFFB);
        wa = inst_in;
        tick();
        ex_ready = 0;
        set_inst(C_R, 12, 13, 14, 0);
        wb2 = inst_in;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_hold", inst_out, wa);
        end
        ex_ready = 1;
        tick();
        chk("bp_next", inst_out, wb2);

        // flush beats a simultaneous hazard
        set_inst(C_LD, 7, 1, 0, 32'd8);
        wl = inst_in;
        tick();
        set_inst(C_R, 8, 7, 7, 0);
        flush = 1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_cnt", 32'(stall_cnt), 32'd1);
        chk("fl_inst", inst_out, wl);
        flush = 0;
        tick();

        // reset while a load-use stall is pending
        set_inst(C_LD, 9, 1, 0, 32'd0);
        tick();
        set_inst(C_R, 10, 9, 0, 0);
        do_reset();
        set_inst(C_R, 1, 5, 0, 0);
        in_valid = 1;
        tick();
        chk("rst_x5", reg1, 32'd0);

        for (int n = 0; n < 600; n++) begin
            int          cls;
            logic [31:0] im;
            cls = $urandom_range(0, 8);
            if ($urandom_range(0, 2) == 0) cls = C_LD;
            im = rimm(cls);
            set_inst(cls, 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), im);
            in_valid = $urandom_range(0, 9) < 8;
            ex_ready = $urandom_range(0, 3) != 0;
            flush    = $urandom_range(0, 15) == 0;
            wb_we    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            tick();
        end
        in_valid = 0; flush = 0; wb_we = 0;

        // NREG=16, CNT_W=2 instance
        s_rst = 0;
        s_wb_we = 1; s_wb_rd = 4; s_wb_data = 32'hAAAA5555;
        s_inst_in = enc(C_R, 1, 20, 4, 0);
        s_in_valid = 1;
        @(posedge clk); #1;
        chk("s_x20_byp", s_reg1, 32'd0);
        chk("s_x4_byp", s_reg2, 32'hAAAA5555);
        s_wb_we = 0;
        @(posedge clk); #1;
        chk("s_x20_file", s_reg1, 32'd0);
        chk("s_x4_file", s_reg2, 32'hAAAA5555);
        for (int k = 1; k <= 5; k++) begin
            s_inst_in = enc(C_LD, 3, 1, 0, 0);
            @(posedge clk); #1;
            s_inst_in = enc(C_R, 4, 3, 0, 0);
            @(posedge clk); #1;
            chk("s_bubble", 32'(s_out_valid), 32'd0);
            chk("s_sat_cnt", 32'(s_stall_cnt), 32'((k < 3) ? k : 3));
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
